// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter command sequencer.
package pc_seq_pkg;

  // Storage width of a command argument; the top zero-extends its CNT_W input into it.
  localparam int unsigned PC_ARG_W = 16;

  typedef enum logic [1:0] {
    OP_RUN  = 2'd0,
    OP_HOLD = 2'd1,
    OP_LOAD = 2'd2,
    OP_STOP = 2'd3
  } pc_op_e;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_RUN  = 3'd2,
    ST_HOLD = 3'd3,
    ST_LOAD = 3'd4,
    ST_STOP = 3'd5
  } pc_seq_state_e;

  typedef struct packed {
    pc_op_e              op;
    logic [PC_ARG_W-1:0] arg;
    logic [2:0]          step;
  } pc_cmd_t;

  // State entered when a command is popped; zero-length RUN/HOLD/STOP collapse to one STOP cycle.
  function automatic pc_seq_state_e entry_state(input pc_cmd_t c);
    pc_seq_state_e s;
    s = ST_STOP;
    if (c.op == OP_LOAD) begin
      s = ST_LOAD;
    end else if (c.arg != '0) begin
      case (c.op)
        OP_RUN:  s = ST_RUN;
        OP_HOLD: s = ST_HOLD;
        default: s = ST_STOP;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/pc_cmd_fifo.sv
// Small synchronous command FIFO with flush; head entry is visible on rd_data.
module pc_cmd_fifo
  import pc_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          flush,
  input  pc_cmd_t                       wr_data,
  output pc_cmd_t                       rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  pc_cmd_t         mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Pointer and occupancy update; flush wins over any push/pop in the same cycle.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Command-driven sequencer for the enhanced program counter pins.
//
//   state | meaning
//   INIT  | after reset/abort; drives pc_reset, then IDLE
//   IDLE  | PC pins quiet; pops the FIFO head when available
//   RUN   | pc_enable with step size, for arg cycles
//   HOLD  | pc_enable + pc_hold, for arg cycles
//   LOAD  | pc_enable + pc_load with load value, one cycle
//   STOP  | PC pins quiet for arg cycles (also zero-length commands)
//
// PC pins are a registered decode of the current state, so they trail the
// state by one cycle; cmd_done rides in the same register stage.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [CNT_W-1:0]            cmd_arg,
  input  logic [2:0]                  cmd_step,
  input  logic                        abort,
  output logic                        pc_reset,
  output logic                        pc_enable,
  output logic                        pc_hold,
  output logic                        pc_load,
  output logic [7:0]                  pc_load_value,
  output logic [2:0]                  pc_step_size,
  output logic                        busy,
  output logic                        cmd_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  pc_seq_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       step_q, step_d;
  logic [7:0]       lv_q, lv_d;

  logic             pc_reset_q, pc_reset_d;
  logic             pc_enable_q, pc_enable_d;
  logic             pc_hold_q, pc_hold_d;
  logic             pc_load_q, pc_load_d;
  logic [7:0]       pc_load_value_q, pc_load_value_d;
  logic [2:0]       pc_step_size_q, pc_step_size_d;
  logic             cmd_done_q, cmd_done_d;

  pc_cmd_t          wr_cmd, head;
  logic             fifo_full, fifo_empty;
  logic             push, pop, active, last;

  assign wr_cmd    = '{op: pc_op_e'(cmd_op), arg: PC_ARG_W'(cmd_arg), step: cmd_step};
  assign cmd_ready = !fifo_full && !abort && (state_q != ST_INIT);
  assign push      = cmd_valid && cmd_ready;
  assign active    = (state_q == ST_RUN) || (state_q == ST_HOLD) ||
                     (state_q == ST_LOAD) || (state_q == ST_STOP);
  assign last      = active && ((state_q == ST_LOAD) || (cnt_q <= CNT_W'(1)));
  assign pop       = !fifo_empty && !abort && ((state_q == ST_IDLE) || last);
  assign busy      = active || !fifo_empty;

  pc_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (abort),
    .wr_data (wr_cmd),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Next state, remaining-cycle down-counter and latched command fields.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    lv_d    = lv_q;
    if (abort) begin
      state_d = ST_INIT;
    end else if (state_q == ST_INIT) begin
      state_d = ST_IDLE;
    end else if ((state_q == ST_IDLE) || last) begin
      if (pop) begin
        state_d = entry_state(head);
        cnt_d   = CNT_W'(head.arg);
        step_d  = head.step;
        lv_d    = 8'(head.arg);
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Pin decode of the current state; abort silences everything including cmd_done.
  always_comb begin
    pc_reset_d      = 1'b0;
    pc_enable_d     = 1'b0;
    pc_hold_d       = 1'b0;
    pc_load_d       = 1'b0;
    pc_load_value_d = '0;
    pc_step_size_d  = '0;
    cmd_done_d      = 1'b0;
    if (!abort) begin
      cmd_done_d = last;
      case (state_q)
        ST_INIT: pc_reset_d = 1'b1;
        ST_RUN: begin
          pc_enable_d    = 1'b1;
          pc_step_size_d = step_q;
        end
        ST_HOLD: begin
          pc_enable_d = 1'b1;
          pc_hold_d   = 1'b1;
        end
        ST_LOAD: begin
          pc_enable_d     = 1'b1;
          pc_load_d       = 1'b1;
          pc_load_value_d = lv_q;
        end
        default: ;
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_INIT;
      cnt_q           <= '0;
      step_q          <= '0;
      lv_q            <= '0;
      pc_reset_q      <= 1'b1;
      pc_enable_q     <= 1'b0;
      pc_hold_q       <= 1'b0;
      pc_load_q       <= 1'b0;
      pc_load_value_q <= '0;
      pc_step_size_q  <= '0;
      cmd_done_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      step_q          <= step_d;
      lv_q            <= lv_d;
      pc_reset_q      <= pc_reset_d;
      pc_enable_q     <= pc_enable_d;
      pc_hold_q       <= pc_hold_d;
      pc_load_q       <= pc_load_d;
      pc_load_value_q <= pc_load_value_d;
      pc_step_size_q  <= pc_step_size_d;
      cmd_done_q      <= cmd_done_d;
    end
  end

  assign pc_reset      = pc_reset_q;
  assign pc_enable     = pc_enable_q;
  assign pc_hold       = pc_hold_q;
  assign pc_load       = pc_load_q;
  assign pc_load_value = pc_load_value_q;
  assign pc_step_size  = pc_step_size_q;
  assign cmd_done      = cmd_done_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues expected pin cycles,
// a negedge monitor pops and compares whenever the PC pins or cmd_done are active.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic [2:0] cmd_step;
  logic       abort;
  logic       pc_reset, pc_enable, pc_hold, pc_load;
  logic [7:0] pc_load_value;
  logic [2:0] pc_step_size;
  logic       busy, cmd_done;
  logic [2:0] fifo_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       en;
    logic       hold;
    logic       load;
    logic [7:0] lv;
    logic [2:0] step;
    logic       done;
    logic [7:0] pc;
    logic       chain;
  } rec_t;

  rec_t       exp_q[$];
  logic [7:0] pc_model;
  logic       pc_pend = 1'b0;
  logic [7:0] pc_exp;
  logic       prev_act = 1'b0;

  pc_sequencer #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_arg       (cmd_arg),
    .cmd_step      (cmd_step),
    .abort         (abort),
    .pc_reset      (pc_reset),
    .pc_enable     (pc_enable),
    .pc_hold       (pc_hold),
    .pc_load       (pc_load),
    .pc_load_value (pc_load_value),
    .pc_step_size  (pc_step_size),
    .busy          (busy),
    .cmd_done      (cmd_done),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  // Behavioural program counter fed by the DUT pins.
  always @(posedge clk) begin
    if (pc_reset)                 pc_model <= 8'h00;
    else if (pc_enable && pc_load) pc_model <= pc_load_value;
    else if (pc_enable && pc_hold) pc_model <= pc_model;
    else if (pc_enable)           pc_model <= pc_model + {5'd0, pc_step_size};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every active pin cycle against the next queued expectation.
  always @(negedge clk) begin
    logic act;
    rec_t r;
    if (reset_n) begin
      if (pc_pend) begin
        check("pc_value", pc_model, pc_exp);
        pc_pend = 1'b0;
      end
      act = pc_enable | pc_hold | pc_load | cmd_done | (pc_step_size != 0) | (pc_load_value != 0);
      if (act) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pins: en=%b hold=%b load=%b lv=%h step=%0d done=%b with empty scoreboard at %0t",
                   pc_enable, pc_hold, pc_load, pc_load_value, pc_step_size, cmd_done, $time);
        end else begin
          r = exp_q.pop_front();
          check("pins", {pc_enable, pc_hold, pc_load, pc_load_value, pc_step_size, cmd_done},
                {r.en, r.hold, r.load, r.lv, r.step, r.done});
          if (r.chain) check("no_gap", prev_act, 1'b1);
          pc_pend = 1'b1;
          pc_exp  = r.pc;
        end
      end
      prev_act = act;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_rec(input logic en, input logic hold, input logic load, input logic [7:0] lv,
                         input logic [2:0] step, input logic done, input logic [7:0] pc, input logic chain);
    rec_t r;
    r.en = en; r.hold = hold; r.load = load; r.lv = lv;
    r.step = step; r.done = done; r.pc = pc; r.chain = chain;
    exp_q.push_back(r);
  endtask

  task automatic push(input logic [1:0] op, input logic [7:0] arg, input logic [2:0] st);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check("push_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_step  = st;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    check("idle_within_budget", (n < 200), 1'b1);
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_arg   = 8'd0;
    cmd_step  = 3'd0;
    abort     = 1'b0;

    // Reset values and release sequence.
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc_reset", pc_reset, 1'b1);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_fifo_count", fifo_count, 3'd0);
    check("rst_pins", {pc_enable, pc_hold, pc_load, pc_load_value, pc_step_size, cmd_done, busy}, 0);
    reset_n = 1'b1;
    tick();
    check("rel1_pc_reset", pc_reset, 1'b1);
    check("rel1_cmd_ready", cmd_ready, 1'b1);
    tick();
    check("rel2_pc_reset", pc_reset, 1'b0);
    check("rel2_cmd_ready", cmd_ready, 1'b1);
    check("rel2_pc_model", pc_model, 8'h00);

    // Single RUN arg=3 step=2 from PC 0.
    exp_rec(1, 0, 0, 8'h00, 3'd2, 0, 8'd2, 0);
    exp_rec(1, 0, 0, 8'h00, 3'd2, 0, 8'd4, 1);
    exp_rec(1, 0, 0, 8'h00, 3'd2, 1, 8'd6, 1);
    push(2'd0, 8'd3, 3'd2);
    check("run_lat_n0", pc_enable, 1'b0);
    tick();
    check("run_lat_n1", pc_enable, 1'b0);
    tick();
    check("run_lat_n2", pc_enable, 1'b1);
    wait_idle();

    // LOAD 0x55 chained into RUN arg=2 step=3.
    exp_rec(1, 0, 1, 8'h55, 3'd0, 1, 8'h55, 0);
    exp_rec(1, 0, 0, 8'h00, 3'd3, 0, 8'h58, 1);
    exp_rec(1, 0, 0, 8'h00, 3'd3, 1, 8'h5B, 1);
    push(2'd2, 8'h55, 3'd0);
    push(2'd0, 8'd2, 3'd3);
    wait_idle();

    // FIFO full during a long RUN, then in-order drain of HOLDs (args 1,2,3,1).
    for (int i = 0; i < 20; i++)
      exp_rec(1, 0, 0, 8'h00, 3'd1, (i == 19), 8'(8'h5C + i), (i != 0));
    exp_rec(1, 1, 0, 8'h00, 3'd0, 1, 8'h6F, 1);
    exp_rec(1, 1, 0, 8'h00, 3'd0, 0, 8'h6F, 1);
    exp_rec(1, 1, 0, 8'h00, 3'd0, 1, 8'h6F, 1);
    exp_rec(1, 1, 0, 8'h00, 3'd0, 0, 8'h6F, 1);
    exp_rec(1, 1, 0, 8'h00, 3'd0, 0, 8'h6F, 1);
    exp_rec(1, 1, 0, 8'h00, 3'd0, 1, 8'h6F, 1);
    exp_rec(1, 1, 0, 8'h00, 3'd0, 1, 8'h6F, 1);
    push(2'd0, 8'd20, 3'd1);
    push(2'd1, 8'd1, 3'd0);
    push(2'd1, 8'd2, 3'd0);
    push(2'd1, 8'd3, 3'd0);
    push(2'd1, 8'd1, 3'd0);
    check("full_count", fifo_count, 3'd4);
    check("full_busy", busy, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_arg   = 8'd5;
    for (int i = 0; i < 3; i++) begin
      check("full_ready_low", cmd_ready, 1'b0);
      tick();
    end
    cmd_valid = 1'b0;
    check("full_count_after_refusal", fifo_count, 3'd4);
    wait_idle();

    // Abort on the 4th RUN pin cycle, with a push offered alongside.
    exp_rec(1, 0, 0, 8'h00, 3'd1, 0, 8'h70, 0);
    exp_rec(1, 0, 0, 8'h00, 3'd1, 0, 8'h71, 1);
    exp_rec(1, 0, 0, 8'h00, 3'd1, 0, 8'h72, 1);
    exp_rec(1, 0, 0, 8'h00, 3'd1, 0, 8'h73, 1);
    push(2'd0, 8'd10, 3'd1);
    repeat (5) tick();
    abort     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    cmd_arg   = 8'd2;
    #1;
    check("abort_ready_low", cmd_ready, 1'b0);
    @(posedge clk);
    #1;
    abort     = 1'b0;
    cmd_valid = 1'b0;
    check("abort_pins_drop", {pc_enable, pc_step_size, cmd_done, pc_reset}, 0);
    check("abort_fifo_count", fifo_count, 3'd0);
    tick();
    check("abort_pc_reset_pulse", pc_reset, 1'b1);
    check("abort_done_quiet", cmd_done, 1'b0);
    tick();
    check("abort_pc_reset_end", pc_reset, 1'b0);
    check("abort_pc_cleared", pc_model, 8'h00);
    check("abort_ready_back", cmd_ready, 1'b1);
    check("abort_no_push", fifo_count, 3'd0);
    wait_idle();

    // Zero-length STOP and HOLD, back to back.
    exp_rec(0, 0, 0, 8'h00, 3'd0, 1, 8'h00, 0);
    exp_rec(0, 0, 0, 8'h00, 3'd0, 1, 8'h00, 1);
    push(2'd3, 8'd0, 3'd0);
    push(2'd1, 8'd0, 3'd5);
    wait_idle();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Command-driven controller for the 8-bit enhanced program counter. It accepts step, hold, load and stop commands through a valid/ready interface and buffers them in a small FIFO. It then drives the counter's `enable`, `hold`, `load`, `load_value`, `step_size` and `reset` pins cycle by cycle, so test and boot logic can script PC behaviour without toggling pins directly. It sits between the command source (boot ROM walker or debug port) and the PC instance.

## Interface

Parameters:
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, minimum 2.
- `CNT_W`, 8: width of the per-command cycle count.

Ports:
- `clk`  in  1  rising-edge clock; one clock domain for the whole block.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO can accept a command.
- `cmd_op`  in  2  0=RUN, 1=HOLD, 2=LOAD, 3=STOP.
- `cmd_arg`  in  CNT_W  cycle count for RUN/HOLD/STOP; load address for LOAD (low 8 bits).
- `cmd_step`  in  3  step size for RUN; ignored otherwise.
- `abort`  in  1  synchronous flush-and-restart.
- `pc_reset`  out  1  to PC `reset`, active high.
- `pc_enable`  out  1  to PC `enable`.
- `pc_hold`  out  1  to PC `hold`.
- `pc_load`  out  1  to PC `load`.
- `pc_load_value`  out  8  to PC `load_value`.
- `pc_step_size`  out  3  to PC `step_size`.
- `busy`  out  1  FSM is executing a command or the FIFO is non-empty.
- `cmd_done`  out  1  one-cycle pulse on the last cycle of each command.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  entries currently buffered.

## Operation

- **Acceptance.** A push happens when `cmd_valid && cmd_ready`.
- **`cmd_ready` rule.** `cmd_ready = !full && !abort && state != INIT`.
- **FSM states.** INIT, IDLE, RUN, HOLD, LOAD, STOP.
  - INIT: `pc_reset=1`, all other PC pins 0. Always moves to IDLE after one cycle.
  - IDLE: all PC pins 0. Pops the FIFO head when the FIFO is non-empty.
  - RUN: `pc_enable=1`, `pc_step_size=cmd_step`, for `cmd_arg` cycles.
  - HOLD: `pc_enable=1`, `pc_hold=1`, for `cmd_arg` cycles.
  - LOAD: `pc_enable=1`, `pc_load=1`, `pc_load_value=cmd_arg[7:0]`, for exactly 1 cycle.
  - STOP: all PC pins 0, for `cmd_arg` cycles.
- **Remaining-cycle counter.** Loaded with `cmd_arg` on pop and decremented each cycle. The command ends on the cycle where the count equals 1.
- **Zero-length commands.** A count of 0 for RUN, HOLD or STOP is consumed as a single STOP-like cycle: PC pins 0 and `cmd_done` pulses.
- **Zero-bubble chaining.** On a command's last cycle, if the FIFO is non-empty, the next entry is popped and the FSM enters its state directly, skipping IDLE. Otherwise it goes to IDLE.
- **Abort.** `abort=1` in any state: on the next edge the FIFO is cleared, the FSM enters INIT (`pc_reset` pulses for one cycle) and `cmd_done` is not pulsed. A push offered in the same cycle is refused, because `cmd_ready=0`.
- **Simultaneous push and pop.** Push and pop in the same cycle leave `fifo_count` unchanged. A push into a full FIFO is impossible by construction.

## Timing

- **Reset values (while `reset_n=0`).** State INIT, `pc_reset=1`, all other outputs 0, `fifo_count=0`, `cmd_ready=0`.
- **First cycle after reset release.** INIT drives `pc_reset=1` for one cycle. From the following cycle the FSM is in IDLE and `cmd_ready=1`.
- **All PC-facing outputs are registered.** Latency is 2 cycles: a command pushed at edge N into an empty, idle block is popped at edge N+1, and its pins are valid from edge N+2.
- **Effect on the PC.** The PC itself updates one edge after the pins, so the first step appears on `pc_out` after edge N+3.
- **`busy`.** Combinational from state and FIFO-empty.
- **`cmd_done`.** Registered and coincident with the command's last active pin cycle.

## Structure

- **Package `pc_seq_pkg`.**
  - Enum `pc_op_e` (RUN, HOLD, LOAD, STOP).
  - Enum `pc_seq_state_e`.
  - Packed struct `pc_cmd_t` {op, arg, step}.
- **Sub-module `pc_cmd_fifo`.**
  - Synchronous FIFO of `pc_cmd_t`, parameterised on `FIFO_DEPTH`.
  - Inputs: push, pop, flush. Outputs: full, empty, count.
  - Same `clk` and `reset_n`.
- **Top module `pc_sequencer`.** Contains the FSM, the remaining-cycle counter and the output registers.

## Test plan

- **Reset.** Assert `reset_n=0` for 2 cycles, then release → `pc_reset=1` during reset and for exactly 1 cycle after, then 0; `cmd_ready` rises on the next cycle.
- **Single RUN.** Push RUN arg=3 step=2 with the PC at 0 → `pc_enable` high for 3 cycles with `pc_step_size=2`, PC reads 2, 4, 6; `cmd_done` pulses once on the third cycle.
- **Back-to-back chaining.** Push LOAD 0x55, then RUN arg=2 step=3 → `pc_load` for 1 cycle, then `pc_enable` on the very next cycle with no IDLE gap; PC sequence 0x55, 0x58, 0x5B.
- **FIFO full.** During RUN arg=20, push 5 HOLD commands → 4 accepted, `fifo_count=4`, `cmd_ready=0` for the 5th; the FIFO then drains in order.
- **Abort mid-RUN.** Push RUN arg=10 step=1 and assert `abort` on its 4th cycle → PC pins drop, `pc_reset` pulses for 1 cycle, `fifo_count=0`, no `cmd_done`.
- **Zero-length commands.** Push STOP arg=0 and HOLD arg=0 → each takes 1 cycle with all PC pins 0, and `cmd_done` pulses twice.
